// File: rtl/tl_ul_sram_slave_pkg.sv
// Shared TileLink-UL opcodes and the D-channel response record used by the SRAM slave and its response queue.
package tl_ul_pkg;

  localparam int TL_DATA_W = 32;
  localparam int TL_SRC_W  = 4;
  localparam int TL_SIZE_W = 3;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic                 denied;
    logic [TL_DATA_W-1:0] data;
  } d_resp_t;

  function automatic logic is_supported(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
  endfunction

endpackage

// File: rtl/tl_ul_sram_slave_if.sv
// TileLink-UL A/D channel bundle; master drives requests, slave returns responses.
interface tl_ul_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 4,
  parameter int SIZE_W = 3
);
  localparam int MASK_W = DATA_W / 8;

  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [SIZE_W-1:0] a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [MASK_W-1:0] a_mask;
  logic [DATA_W-1:0] a_data;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [SIZE_W-1:0] d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic [DATA_W-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
  );

endinterface

// File: rtl/tl_ul_resp_queue.sv
// Two-entry FIFO of D-channel responses; exposes occupancy so the top can issue A-channel credit.
module tl_ul_resp_queue
  import tl_ul_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    enq_valid,
  input  d_resp_t enq_data,
  input  logic    deq_ready,
  output logic    deq_valid,
  output d_resp_t deq_data,
  output logic [1:0] count
);

  d_resp_t mem [2];
  logic    wr_ptr;
  logic    rd_ptr;
  logic    push;
  logic    pop;

  assign push      = enq_valid;
  assign pop       = deq_valid && deq_ready;
  assign deq_valid = (count != 2'd0);
  assign deq_data  = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: an entry is only visible once count covers it.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL slave fronting a 1-cycle-read SRAM with a 2-entry D queue and credit-based A backpressure.
// Optional TL_SRAM_RANGE_CHECK_EN: deny out-of-window, oversize and misaligned requests.
module tl_ul_sram_slave
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = TL_DATA_W,
  parameter int SRC_W     = TL_SRC_W,
  parameter int SIZE_W    = TL_SIZE_W,
  parameter int MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0800_0000),
  localparam int MASK_W   = DATA_W / 8,
  localparam int MEM_AW   = $clog2(MEM_WORDS),
  localparam int LANE_SH  = $clog2(MASK_W)
) (
  input  logic              clock,
  input  logic              reset,
  tl_ul_sram_slave_if.slave tl,
  output logic              sram_en,
  output logic              sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic              fire;
  logic              denied_p0;
  logic              is_write_p0;
  logic              access_p0;
  logic [ADDR_W-1:0] offset_p0;
  logic [MEM_AW-1:0] word_p0;
  logic [1:0]        q_count;

  logic              vld_p1;
  logic [2:0]        op_p1;
  logic [SIZE_W-1:0] size_p1;
  logic [SRC_W-1:0]  source_p1;
  logic              denied_p1;
  logic              rd_p1;
  d_resp_t           enq_resp;
  d_resp_t           head;
  logic              head_vld;
  logic              unused_bits;

  // Stage 0: credit, decode and SRAM strobe in the accept cycle.
  assign tl.a_ready  = !reset && (({1'b0, q_count} + {2'b00, vld_p1}) < 3'd2);
  assign fire        = tl.a_valid && tl.a_ready;
  assign offset_p0   = tl.a_address - BASE_ADDR;
  assign word_p0     = offset_p0[MEM_AW+LANE_SH-1:LANE_SH];
  assign is_write_p0 = (tl.a_opcode == PUT_FULL) || (tl.a_opcode == PUT_PARTIAL);

`ifdef TL_SRAM_RANGE_CHECK_EN
  logic              in_range_p0;
  logic              size_ok_p0;
  logic [ADDR_W-1:0] align_mask_p0;

  // Wrapping subtraction turns addresses below BASE_ADDR into large offsets, so one compare covers both ends.
  assign in_range_p0   = offset_p0 < ADDR_W'(MEM_WORDS * MASK_W);
  assign size_ok_p0    = tl.a_size <= SIZE_W'(LANE_SH);
  assign align_mask_p0 = (ADDR_W'(1) << tl.a_size) - ADDR_W'(1);
  assign denied_p0     = !is_supported(tl.a_opcode) || !in_range_p0 || !size_ok_p0
                         || ((tl.a_address & align_mask_p0) != '0);
`else
  assign denied_p0     = !is_supported(tl.a_opcode);
`endif

  assign access_p0  = fire && !denied_p0;
  assign sram_en    = access_p0;
  assign sram_we    = access_p0 && is_write_p0;
  assign sram_addr  = access_p0 ? word_p0 : '0;
  assign sram_wmask = (access_p0 && is_write_p0) ? tl.a_mask : '0;
  assign sram_wdata = (access_p0 && is_write_p0) ? tl.a_data : '0;

  // Stage 1: one request in flight while the SRAM read completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= fire;
  end

  always_ff @(posedge clock) begin
    if (fire) begin
      op_p1     <= (tl.a_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
      size_p1   <= tl.a_size;
      source_p1 <= tl.a_source;
      denied_p1 <= denied_p0;
      rd_p1     <= (tl.a_opcode == GET) && !denied_p0;
    end
  end

  always_comb begin
    enq_resp        = '0;
    enq_resp.opcode = op_p1;
    enq_resp.size   = size_p1;
    enq_resp.source = source_p1;
    enq_resp.denied = denied_p1;
    enq_resp.data   = rd_p1 ? sram_rdata : '0;
  end

  // Stage 2: queued responses presented on D.
  tl_ul_resp_queue u_resp_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (vld_p1),
    .enq_data  (enq_resp),
    .deq_ready (tl.d_ready),
    .deq_valid (head_vld),
    .deq_data  (head),
    .count     (q_count)
  );

  assign tl.d_valid  = head_vld;
  assign tl.d_opcode = head_vld ? head.opcode : '0;
  assign tl.d_size   = head_vld ? head.size   : '0;
  assign tl.d_source = head_vld ? head.source : '0;
  assign tl.d_denied = head_vld ? head.denied : 1'b0;
  assign tl.d_data   = head_vld ? head.data   : '0;
  assign tl.d_param  = 2'd0;
  assign tl.d_sink   = 1'b0;

  assign unused_bits = ^{tl.a_param, offset_p0};

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Directed bench for tl_ul_sram_slave with a byte-masked 1-cycle-read SRAM model.
module tb_tl_ul_sram_slave;
  import tl_ul_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sram_en;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [31:0] mem [1024];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        en_s;
  logic        we_s;
  logic [9:0]  addr_s;

  always #5 clock = ~clock;

  tl_ul_sram_slave_if #(.ADDR_W(32), .DATA_W(32), .SRC_W(4), .SIZE_W(3)) bus ();

  tl_ul_sram_slave dut (
    .clock      (clock),
    .reset      (reset),
    .tl         (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [3:0] src);
    logic ok;
    ok            = 1'b0;
    bus.a_opcode  = op;
    bus.a_address = addr;
    bus.a_data    = data;
    bus.a_mask    = mask;
    bus.a_source  = src;
    bus.a_size    = 3'd2;
    bus.a_valid   = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (bus.a_ready) begin
        ok     = 1'b1;
        en_s   = sram_en;
        we_s   = sram_we;
        addr_s = sram_addr;
      end
      @(posedge clock); #1;
    end
    bus.a_valid = 1'b0;
    chk("a_accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic expect_d(input logic [2:0] op, input logic [3:0] src, input logic den,
                          input logic [31:0] data, input string tag);
    logic ok;
    ok          = 1'b0;
    bus.d_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (bus.d_valid) begin
        ok = 1'b1;
        chk({tag, ".opcode"}, {61'd0, bus.d_opcode}, {61'd0, op});
        chk({tag, ".source"}, {60'd0, bus.d_source}, {60'd0, src});
        chk({tag, ".denied"}, {63'd0, bus.d_denied}, {63'd0, den});
        chk({tag, ".data"},   {32'd0, bus.d_data},   {32'd0, data});
        chk({tag, ".size"},   {61'd0, bus.d_size},   64'd2);
        chk({tag, ".param_sink"}, {61'd0, bus.d_param, bus.d_sink}, 64'd0);
      end
      @(posedge clock); #1;
    end
    bus.d_ready = 1'b0;
    chk({tag, ".d_valid_seen"}, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    bus.a_valid   = 1'b0;
    bus.a_opcode  = 3'd0;
    bus.a_param   = 3'd0;
    bus.a_size    = 3'd2;
    bus.a_source  = 4'd0;
    bus.a_address = 32'd0;
    bus.a_mask    = 4'd0;
    bus.a_data    = 32'd0;
    bus.d_ready   = 1'b0;

    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.a_ready", {63'd0, bus.a_ready}, 64'd0);
    chk("rst.d_valid", {63'd0, bus.d_valid}, 64'd0);
    chk("rst.sram_en", {63'd0, sram_en}, 64'd0);
    chk("rst.d_data",  {32'd0, bus.d_data}, 64'd0);
    reset = 1'b0;
    #1 chk("rst_release.a_ready", {63'd0, bus.a_ready}, 64'd1);
    @(posedge clock); #1;

    // Preload words 5 and 0.
    send(PUT_FULL, 32'h0800_0014, 32'h1111_2222, 4'hF, 4'd0);
    chk("pre.sram_addr", {54'd0, addr_s}, 64'd5);
    send(PUT_FULL, 32'h0800_0000, 32'hCAFE_0000, 4'hF, 4'd0);
    expect_d(ACCESS_ACK, 4'd0, 1'b0, 32'h0, "pre_ack0");
    expect_d(ACCESS_ACK, 4'd0, 1'b0, 32'h0, "pre_ack1");

    // PutFull then Get of the same word.
    send(PUT_FULL, 32'h0800_0010, 32'hDEAD_BEEF, 4'hF, 4'd3);
    chk("put.sram_en",   {63'd0, en_s}, 64'd1);
    chk("put.sram_we",   {63'd0, we_s}, 64'd1);
    chk("put.sram_addr", {54'd0, addr_s}, 64'd4);
    send(GET, 32'h0800_0010, 32'h0, 4'hF, 4'd5);
    chk("get.sram_en", {63'd0, en_s}, 64'd1);
    chk("get.sram_we", {63'd0, we_s}, 64'd0);
    expect_d(ACCESS_ACK,      4'd3, 1'b0, 32'h0,         "put_ack");
    expect_d(ACCESS_ACK_DATA, 4'd5, 1'b0, 32'hDEAD_BEEF, "get_full");

    // PutPartial on byte lane 1, read back immediately.
    send(PUT_PARTIAL, 32'h0800_0010, 32'h0000_AB00, 4'h2, 4'd1);
    send(GET, 32'h0800_0010, 32'h0, 4'hF, 4'd2);
    expect_d(ACCESS_ACK,      4'd1, 1'b0, 32'h0,         "pp_ack");
    expect_d(ACCESS_ACK_DATA, 4'd2, 1'b0, 32'hDEAD_ABEF, "pp_get");

    // Three back-to-back Gets with D stalled.
    bus.a_opcode  = GET;
    bus.a_mask    = 4'hF;
    bus.a_size    = 3'd2;
    bus.a_address = 32'h0800_0010;
    bus.a_source  = 4'd7;
    bus.a_valid   = 1'b1;
    @(negedge clock);
    chk("bp.ready0", {63'd0, bus.a_ready}, 64'd1);
    @(posedge clock); #1;
    bus.a_address = 32'h0800_0014;
    bus.a_source  = 4'd8;
    @(negedge clock);
    chk("bp.ready1", {63'd0, bus.a_ready}, 64'd1);
    @(posedge clock); #1;
    bus.a_address = 32'h0800_0000;
    bus.a_source  = 4'd9;
    @(negedge clock);
    chk("bp.ready_drop", {63'd0, bus.a_ready}, 64'd0);
    chk("bp.d_valid",    {63'd0, bus.d_valid}, 64'd1);
    chk("bp.src_a",      {60'd0, bus.d_source}, 64'd7);
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp.ready_full", {63'd0, bus.a_ready}, 64'd0);
    chk("bp.src_hold",   {60'd0, bus.d_source}, 64'd7);
    chk("bp.data_hold",  {32'd0, bus.d_data}, 64'hDEAD_ABEF);
    @(posedge clock); #1;
    expect_d(ACCESS_ACK_DATA, 4'd7, 1'b0, 32'hDEAD_ABEF, "bp_r0");
    @(negedge clock);
    chk("bp.reopen", {63'd0, bus.a_ready}, 64'd1);
    @(posedge clock); #1;
    bus.a_valid = 1'b0;
    expect_d(ACCESS_ACK_DATA, 4'd8, 1'b0, 32'h1111_2222, "bp_r1");
    expect_d(ACCESS_ACK_DATA, 4'd9, 1'b0, 32'hCAFE_0000, "bp_r2");

    // Unsupported opcodes are denied with no SRAM access.
    send(3'd2, 32'h0800_0010, 32'hFFFF_FFFF, 4'hF, 4'd4);
    chk("arith.sram_en", {63'd0, en_s}, 64'd0);
    expect_d(ACCESS_ACK, 4'd4, 1'b1, 32'h0, "arith");
    send(3'd7, 32'h0800_0010, 32'hFFFF_FFFF, 4'hF, 4'd13);
    chk("op7.sram_en", {63'd0, en_s}, 64'd0);
    expect_d(ACCESS_ACK, 4'd13, 1'b1, 32'h0, "op7");
    chk("arith.mem_kept", {32'd0, mem[4]}, 64'hDEAD_ABEF);

    // One window past the end of the SRAM.
    send(GET, 32'h0800_1000, 32'h0, 4'hF, 4'd6);
`ifdef TL_SRAM_RANGE_CHECK_EN
    chk("oor.sram_en", {63'd0, en_s}, 64'd0);
    expect_d(ACCESS_ACK_DATA, 4'd6, 1'b1, 32'h0, "oor");
`else
    chk("wrap.sram_addr", {54'd0, addr_s}, 64'd0);
    expect_d(ACCESS_ACK_DATA, 4'd6, 1'b0, 32'hCAFE_0000, "wrap");
`endif

    // Reset with two responses queued.
    send(GET, 32'h0800_0010, 32'h0, 4'hF, 4'd10);
    send(GET, 32'h0800_0014, 32'h0, 4'hF, 4'd11);
    @(posedge clock); #1;
    chk("mid.d_valid", {63'd0, bus.d_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst.d_valid", {63'd0, bus.d_valid}, 64'd0);
    chk("mid_rst.a_ready", {63'd0, bus.a_ready}, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus.d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_rst.no_stale", {63'd0, bus.d_valid}, 64'd0);
    end
    chk("post_rst.a_ready", {63'd0, bus.a_ready}, 64'd1);
    bus.d_ready = 1'b0;
    @(posedge clock); #1;
    send(GET, 32'h0800_0010, 32'h0, 4'hF, 4'd12);
    expect_d(ACCESS_ACK_DATA, 4'd12, 1'b0, 32'hDEAD_ABEF, "post_rst_get");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
